icache_rv32: RTL
================

// Module: icache_rv32
// PURPOSE
//  Direct-mapped instruction cache answering the IF stage's PC fetch address.
//  - Returns the instruction word combinationally on a hit.
//  - On a miss, asserts the IF instruction-side stall (oStallI) and refills
//    the whole line from backing memory over a REQ/ACK word handshake.
//  - Sits between the IF stage (PC out) and the instruction memory.
// PARAMETERS
//  LINES  16  number of cache lines; power of two, >=2
//  WORDS  4   32-bit words per line; power of two, >=2
// PORTS
//  iCLK       in   1   clock; all state updates on the rising edge
//  iRST       in   1   synchronous reset, active-low (0 = reset)
//  iPCADDR    in   32  fetch address from IF; bits[1:0] ignored
//  oINSTR     out  32  instruction word; 32'h00000013 (NOP) whenever oStallI=1
//  oStallI    out  1   1 = instruction not available this cycle, IF holds PC
//  iFLUSH     in   1   1-cycle pulse: invalidate every line (fence.i)
//  oMemADDR   out  32  word address of the refill beat, bits[1:0]=0
//  oMemREQ    out  1   refill beat request
//  iMemACK    in   1   beat accepted; iMemDATA valid in this same cycle
//  iMemDATA   in   32  refill data
// BEHAVIOUR
//  - Address split: OFF=[OB+1:2], IDX=[OB+IB+1:OB+2], TAG=[31:OB+IB+2],
//    with OB=log2(WORDS), IB=log2(LINES). Default: OFF[3:2], IDX[7:4], TAG[31:8].
//  - hit = valid[IDX] & (tag[IDX]==TAG) & (state==IDLE). Purely combinational.
//  - oStallI = ~hit; oINSTR = hit ? data[IDX][OFF] : NOP.
//  - Reset (iRST=0): all valid bits=0, state=IDLE, oMemREQ=0, oMemADDR=0,
//    beat counter=0, flush-pending=0. Tag/data arrays are not reset.
//    Hence oStallI=1 after reset until the first refill completes.
//  - FSM states: IDLE, REFILL, FILL_DONE.
//    IDLE->REFILL on a miss (and not iFLUSH):
//      latch line base {TAG,IDX,OB'b0,2'b00}; counter k=0;
//      oMemREQ=1, oMemADDR=base.
//    REFILL: hold oMemREQ/oMemADDR stable until iMemACK.
//      On ACK: data[IDX][k] <= iMemDATA.
//      If k<WORDS-1: k<=k+1, oMemADDR<=base+4*(k+1).
//      Else: oMemREQ<=0, go to FILL_DONE.
//      Wait states of any length are legal; oMemREQ never drops without ACK.
//    FILL_DONE (1 cycle): tag[IDX]<=latched TAG; valid[IDX]<=~flush-pending;
//      clear flush-pending; ->IDLE. Hit is visible the following cycle.
//  - Miss latency: 1 (IDLE detect) + WORDS beats with zero wait + 1 (FILL_DONE).
//    With the default WORDS=4 and no memory wait states, the hit appears 6 cycles
//    after a cold-miss address is presented.
//  - Refill always uses the latched base. iPCADDR changes during refill do not
//    abort it. After refill, lookup restarts with the current iPCADDR.
//  - iFLUSH in IDLE: all valid<=0 next cycle; no refill starts that cycle.
//  - iFLUSH during REFILL/FILL_DONE: all valid<=0 and set flush-pending. The
//    refill completes, but the filled line is left invalid.
//  - Reset asserted mid-refill: the FSM aborts immediately to IDLE with
//    oMemREQ=0. Memory must tolerate a dropped request under reset.
//  - Replacement: direct-mapped overwrite. The old valid bit is cleared on entry
//    to REFILL, so a half-filled line is never reported as a hit.
// STRUCTURE
//  - Shared include rv32_defs.vh: RV32_NOP (32'h00000013); IC_IDLE/IC_REFILL/
//    IC_FILL_DONE encodings; XLEN=32.
//  - One sub-module: icache_mem_rv32.
//    LINES x WORDS x 32 data array plus tag array.
//    Async read, one synchronous write port.
//    Valid bits and the FSM stay in icache_rv32.
// TESTING (LINES=16, WORDS=4, memory returns data = address ^ 32'hA5A5A5A5)
//  1. Release reset, iPCADDR=0x00000000, zero wait states:
//     - oStallI=1, NOP out.
//     - REQ beats at 0x0,0x4,0x8,0xC.
//     - 6th cycle: oStallI=0, oINSTR=0xA5A5A5A5.
//  2. After test 1, iPCADDR=0x4,0x8,0xC on consecutive cycles:
//     - three hits, oStallI=0, no oMemREQ.
//  3. Conflict: iPCADDR=0x00000100 (same IDX 0, TAG 1):
//     - refill 0x100..0x10C.
//     - then 0x0 misses again and refills.
//  4. Wait states: iMemACK delayed 3 cycles per beat.
//     - oMemREQ/oMemADDR stable while waiting.
//     - total miss 1+4*4+1 = 18 cycles.
//  5. iFLUSH pulse during beat 2 of a refill:
//     - refill finishes.
//     - same address misses again (new 4-beat refill).
//  6. Reset pulse during beat 1:
//     - next cycle oMemREQ=0, state IDLE, oStallI=1.
//     - fresh refill starts at beat 0 after release.

Source files
------------

// File: rtl/icache_rv32_pkg.sv
// Shared RV32 constants and the I-cache controller state encoding.
package icache_rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IC_IDLE      = 2'd0,
    IC_REFILL    = 2'd1,
    IC_FILL_DONE = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_rv32_mem.sv
// Tag and data storage for the direct-mapped I-cache: async read, synchronous write.
module icache_mem_rv32
  import icache_rv32_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TW    = 24
) (
  input  logic                     clk_i,
  input  logic [$clog2(LINES)-1:0] rd_idx_i,
  input  logic [$clog2(WORDS)-1:0] rd_off_i,
  output logic [XLEN-1:0]          rd_data_o,
  output logic [TW-1:0]            rd_tag_o,
  input  logic [$clog2(LINES)-1:0] wr_idx_i,
  input  logic                     wr_data_en_i,
  input  logic [$clog2(WORDS)-1:0] wr_off_i,
  input  logic [XLEN-1:0]          wr_data_i,
  input  logic                     wr_tag_en_i,
  input  logic [TW-1:0]            wr_tag_i
);

  logic [XLEN-1:0] data_q [LINES][WORDS];
  logic [TW-1:0]   tag_q  [LINES];

  always_ff @(posedge clk_i) begin
    if (wr_data_en_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (wr_tag_en_i)  tag_q[wr_idx_i]            <= wr_tag_i;
  end

  assign rd_data_o = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o  = tag_q[rd_idx_i];

endmodule

// File: rtl/icache_rv32.sv
// Direct-mapped RV32 instruction cache; combinational hit path, line refill over REQ/ACK.
module icache_rv32
  import icache_rv32_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iPCADDR,
  output logic [XLEN-1:0] oINSTR,
  output logic            oStallI,
  input  logic            iFLUSH,
  output logic [XLEN-1:0] oMemADDR,
  output logic            oMemREQ,
  input  logic            iMemACK,
  input  logic [XLEN-1:0] iMemDATA
);

  localparam int unsigned OB = $clog2(WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TW = XLEN - OB - IB - 2;

  ic_state_e       state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   ltag_q;
  logic [IB-1:0]   lidx_q;
  logic [OB-1:0]   cnt_q;
  logic            fpend_q;
  logic            req_q;
  logic [XLEN-1:0] addr_q;

  logic [OB-1:0]   pc_off;
  logic [IB-1:0]   pc_idx;
  logic [TW-1:0]   pc_tag;
  logic [XLEN-1:0] rd_data;
  logic [TW-1:0]   rd_tag;
  logic            hit;
  logic            data_we;
  logic            tag_we;
  logic            unused_pc;

  assign pc_off    = iPCADDR[OB+1:2];
  assign pc_idx    = iPCADDR[OB+IB+1:OB+2];
  assign pc_tag    = iPCADDR[XLEN-1:OB+IB+2];
  assign unused_pc = ^iPCADDR[1:0];

  assign hit     = valid_q[pc_idx] && (rd_tag == pc_tag) && (state_q == IC_IDLE);
  assign oStallI = ~hit;
  assign oINSTR  = hit ? rd_data : RV32_NOP;
  assign oMemREQ  = req_q;
  assign oMemADDR = addr_q;

  assign data_we = iRST && (state_q == IC_REFILL) && iMemACK;
  assign tag_we  = iRST && (state_q == IC_FILL_DONE);

  icache_mem_rv32 #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TW    (TW)
  ) u_mem (
    .clk_i        (iCLK),
    .rd_idx_i     (pc_idx),
    .rd_off_i     (pc_off),
    .rd_data_o    (rd_data),
    .rd_tag_o     (rd_tag),
    .wr_idx_i     (lidx_q),
    .wr_data_en_i (data_we),
    .wr_off_i     (cnt_q),
    .wr_data_i    (iMemDATA),
    .wr_tag_en_i  (tag_we),
    .wr_tag_i     (ltag_q)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= IC_IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (!hit && !iFLUSH) begin
            state_q         <= IC_REFILL;
            ltag_q          <= pc_tag;
            lidx_q          <= pc_idx;
            cnt_q           <= '0;
            req_q           <= 1'b1;
            addr_q          <= {pc_tag, pc_idx, {(OB+2){1'b0}}};
            valid_q[pc_idx] <= 1'b0;
          end
        end
        IC_REFILL: begin
          if (iMemACK) begin
            if (cnt_q == OB'(WORDS-1)) begin
              req_q   <= 1'b0;
              state_q <= IC_FILL_DONE;
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        IC_FILL_DONE: begin
          valid_q[lidx_q] <= ~fpend_q;
          fpend_q         <= 1'b0;
          state_q         <= IC_IDLE;
        end
        default: state_q <= IC_IDLE;
      endcase
      // A flush in FILL_DONE needs no pending flag: clearing all valids here already covers the line.
      if (iFLUSH) begin
        valid_q <= '0;
        if (state_q == IC_REFILL) fpend_q <= 1'b1;
      end
    end
  end

endmodule
